// File: rtl/flag_update_unit_pkg.sv
// Shared definitions for the NZCV flag path: ARM data-processing opcodes,
// opcode class predicates and flag bit positions.
package flag_update_unit_pkg;

  localparam int unsigned NZCV_W = 4;

  // Bit positions inside every 4-bit NZCV vector (state, bypass, MSR data).
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_EOR = 4'b0001,
    OP_SUB = 4'b0010,
    OP_RSB = 4'b0011,
    OP_ADD = 4'b0100,
    OP_ADC = 4'b0101,
    OP_SBC = 4'b0110,
    OP_RSC = 4'b0111,
    OP_TST = 4'b1000,
    OP_TEQ = 4'b1001,
    OP_CMP = 4'b1010,
    OP_CMN = 4'b1011,
    OP_ORR = 4'b1100,
    OP_MOV = 4'b1101,
    OP_BIC = 4'b1110,
    OP_MVN = 4'b1111
  } dp_opcode_e;

  // Adder-based opcodes take C/V from the adder; everything else is logical.
  function automatic logic is_arith_op(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_SUB, OP_RSB, OP_ADD, OP_ADC,
      OP_SBC, OP_RSC, OP_CMP, OP_CMN: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

  // Test/compare opcodes always write flags, whatever the S bit says.
  function automatic logic is_compare_op(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_TST, OP_TEQ, OP_CMP, OP_CMN: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/flag_update_unit_flag_gen.sv
// Pure combinational NZCV computation for one data-processing result.
module flag_gen
  import flag_update_unit_pkg::*;
(
  input  logic [3:0]        opcode,
  input  logic [31:0]       alu_result,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              shifter_carry,
  input  logic              old_v,
  output logic [NZCV_W-1:0] flags
);

  logic arith;

  always_comb begin
    flags  = '0;
    arith  = is_arith_op(opcode);
    flags[FLAG_N] = alu_result[31];
    flags[FLAG_Z] = (alu_result == 32'h0);
    // Logical ops leave V untouched and take C from the barrel shifter.
    flags[FLAG_C] = arith ? alu_carry    : shifter_carry;
    flags[FLAG_V] = arith ? alu_overflow : old_v;
  end

endmodule

// File: rtl/flag_update_unit.sv
// NZCV flag register with MSR override, same-cycle bypass to the condition
// checker, and a saturating count of committed flag writes.
module flag_update_unit
  import flag_update_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_s,
  input  logic [3:0]        ex_opcode,
  input  logic [31:0]       alu_result,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              shifter_carry,
  input  logic              freeze,
  input  logic              msr_we,
  input  logic [3:0]        msr_data,
  output logic [NZCV_W-1:0] nzcv_q,
  output logic [NZCV_W-1:0] nzcv_fwd,
  output logic              update_pending,
  output logic [CNT_W-1:0]  update_cnt
);

  // ex_valid / msr_we are single-cycle qualifiers with no back-pressure:
  // a request is consumed on the rising edge where it is high and freeze is
  // low; with freeze high it is dropped, and the producer re-presents it.
  logic [NZCV_W-1:0] nzcv_d;
  logic [NZCV_W-1:0] gen_flags;
  logic [CNT_W-1:0]  update_cnt_q;
  logic [CNT_W-1:0]  update_cnt_d;
  logic              ex_write;
  logic              commit;

  flag_gen u_flag_gen (
    .opcode        (ex_opcode),
    .alu_result    (alu_result),
    .alu_carry     (alu_carry),
    .alu_overflow  (alu_overflow),
    .shifter_carry (shifter_carry),
    .old_v         (nzcv_q[FLAG_V]),
    .flags         (gen_flags)
  );

  always_comb begin
    ex_write     = 1'b0;
    commit       = 1'b0;
    nzcv_d       = nzcv_q;
    update_cnt_d = update_cnt_q;

    // ex_valid gates first so opcode/S garbage cannot leak when idle.
    ex_write = ex_valid & (ex_s | is_compare_op(ex_opcode));
    commit   = ~freeze & (msr_we | ex_write);

    if (commit) begin
      nzcv_d = msr_we ? msr_data : gen_flags;
      if (update_cnt_q != {CNT_W{1'b1}}) begin
        update_cnt_d = update_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nzcv_q       <= '0;
      update_cnt_q <= '0;
    end else begin
      nzcv_q       <= nzcv_d;
      update_cnt_q <= update_cnt_d;
    end
  end

  assign nzcv_fwd       = nzcv_d;
  assign update_pending = commit;
  assign update_cnt     = update_cnt_q;

endmodule
